// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I main controller. The ALU decoder uses the same ALUOp values.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_JAL, S_ALUWB, S_BEQ
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_imm_src_dec.sv
// Immediate-format select for the extend unit, decoded straight from the opcode.
module mc_imm_src_dec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl_fsm.sv
// Multicycle RV32I main controller: Moore FSM, datapath controls and retired-instruction counter.
// Optional MC_MEM_STALL_EN adds a mem_ready handshake that stalls FETCH, MEMREAD and MEMWRITE.
module mc_main_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
`ifdef MC_MEM_STALL_EN
    input  logic             mem_ready,
`endif
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       imm_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic             mem_ok;
    logic             fetch_ok;
    logic             op_legal;

`ifdef MC_MEM_STALL_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    assign op_legal = op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ok) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
            S_MEMWRITE: begin
                if (mem_ok) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_MEMWB, S_ALUWB, S_BEQ: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_EXEC_R, S_EXEC_I, S_JAL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
        // Controls are registered alongside the state so outputs come straight off flops.
        ctrl_d    = state_ctrl(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ctrl_q    <= state_ctrl(S_FETCH);
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            instret_q <= instret_d;
        end
    end

    // Only FETCH carries ir_write, so it doubles as the "this cycle waits on memory" flag.
    assign fetch_ok   = mem_ok | ~ctrl_q.ir_write;

    assign pc_write   = rst_n & ((ctrl_q.pc_update & fetch_ok) | (ctrl_q.branch & zero));
    assign ir_write   = rst_n & ctrl_q.ir_write & fetch_ok;
    assign adr_src    = rst_n & ctrl_q.adr_src;
    assign mem_write  = rst_n & ctrl_q.mem_write;
    assign reg_write  = rst_n & ctrl_q.reg_write;
    assign result_src = rst_n ? ctrl_q.result_src : 2'b00;
    assign alu_src_a  = rst_n ? ctrl_q.alu_src_a  : 2'b00;
    assign alu_src_b  = rst_n ? ctrl_q.alu_src_b  : 2'b00;
    assign alu_op     = rst_n ? ctrl_q.alu_op     : 2'b00;
    assign illegal    = rst_n & (state_q == S_DECODE) & ~op_legal;
    assign instret    = rst_n ? instret_q : '0;

    mc_imm_src_dec u_imm_src_dec (
        .op      (op),
        .imm_src (imm_src)
    );

endmodule
